expr_eval: RTL and testbench
============================

Name: expr_eval

Overview:
- Downstream stage of the ASCII expression-string checker. Consumes the same byte stream (single-digit operands, '+' and '*' operators) and computes the integer value with standard precedence ('*' binds tighter than '+').
- The string is terminated by '='. On the terminator it emits a one-cycle result strobe with the value or an error flag.
- Sits between the character source and any display or compare logic.

Parameters:
- W, 16, result/accumulator width; all arithmetic is modulo 2^W.

Ports:
- clk  input  1  system clock, rising edge
- clr_n  input  1  asynchronous active-low reset
- in_valid  input  1  byte on in is consumed this cycle when high
- in  input  8  ASCII character
- result  output  W  value of the last terminated expression; 0 on error
- done  output  1  one-cycle pulse, cycle after '=' is accepted
- err  output  1  valid with done; 1 means the expression was malformed
- busy  output  1  high while an expression is in progress (state != S_START)

Behaviour:
- Reset (clr_n low, asynchronous): state=S_START, sum=0, prod=0, result=0, done=0, err=0.
- Character classes: DIG = '0'..'9' (value in-8'h30); ADD = '+'; MUL = '*'; EQ = '='; any other byte is BAD.
- in_valid low: no state change; done/err deassert.
- Registers: sum (W bits, completed additive terms), prod (W bits, current multiplicative term).
- States and transitions, evaluated only when in_valid=1:
  - S_START (expects digit): DIG -> prod=d, sum=0, go to S_NUM. EQ -> done=1, err=1, result=0, stay. ADD/MUL/BAD -> S_ERR.
  - S_NUM (expects operator or '='): ADD -> sum=sum+prod, go to S_OPA. MUL -> go to S_OPM. EQ -> result=sum+prod, done=1, err=0, sum=prod=0, go to S_START. DIG/BAD -> S_ERR.
  - S_OPA (after '+'): DIG -> prod=d, go to S_NUM. EQ -> error completion (done=1, err=1, result=0), go to S_START. Other -> S_ERR.
  - S_OPM (after '*'): DIG -> prod=prod*d (low W bits), go to S_NUM. EQ -> error completion, go to S_START. Other -> S_ERR.
  - S_ERR: all bytes ignored except EQ -> error completion, go to S_START.
- Latency: result, done and err are registered and visible exactly 1 cycle after the '=' edge. done never holds for 2 consecutive cycles unless two '=' bytes arrive back to back.
- Overflow: wraps silently modulo 2^W and is not an error.
- Back-to-back expressions: a DIG in the cycle right after '=' starts a new expression; no idle cycle is required.
- result holds its last value until the next completion.
- Reset mid-expression aborts it. No done pulse is issued for the aborted expression.

Optional Feature:
- Macro: EXPR_EVAL_SUB_EN.
- Defined: '-' becomes an operator class SUB. In S_NUM, SUB -> sum=sum+prod, go to S_OPS. In S_OPS, DIG -> prod=(-d) mod 2^W (two's complement), go to S_NUM. A subsequent '*' multiplies the negated term.
- Not defined: '-' is BAD, and S_OPS does not exist in the encoding.

Decomposition:
- Shared package expr_pkg holds:
  - state encoding localparams S_START, S_NUM, S_OPA, S_OPM, S_OPS, S_ERR;
  - character constants CH_ADD, CH_MUL, CH_EQ, CH_SUB, CH_0, CH_9;
  - char-class codes DIG, ADD, MUL, SUB, EQ, BAD.
- One sub-module, expr_char_class: purely combinational, in -> {class, digit[3:0]}. It is shared with the upstream checker. The FSM and datapath stay in expr_eval.

Test Plan:
- "1+1*2=" with in_valid=1 each cycle -> done=1 one cycle after '=', result=3, err=0.
- "2*3+4*5=" with in_valid gaps (low 2 cycles between bytes) -> result=26, err=0. done is a single pulse.
- "1++2=" and a lone "=" -> each gives done=1, err=1, result=0. The next "7=" -> result=7, err=0.
- W=16, "9*9*9*9*9*9=" -> result=7153 (531441 mod 65536), err=0.
- Stream "1+2", then clr_n low mid-cycle for 3 cycles, then "3=" -> outputs 0 during reset, no done for the aborted expression, then result=3.
- With EXPR_EVAL_SUB_EN: "5-2*2=" -> result=1. Without the macro, the same stream -> err=1, result=0.

Source files
------------

// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared state, character and class encodings for the expression evaluator
//
// Used by expr_char_class (also shared with the upstream string checker) and expr_eval.
// Optional feature macro: EXPR_EVAL_SUB_EN (adds '-' as an operator and the S_OPS state).
package expr_pkg;

    // FSM states; S_OPS only exists when subtraction is built in.
    typedef enum logic [2:0] {
        S_START = 3'd0,
        S_NUM   = 3'd1,
        S_OPA   = 3'd2,
        S_OPM   = 3'd3,
`ifdef EXPR_EVAL_SUB_EN
        S_OPS   = 3'd4,
`endif
        S_ERR   = 3'd5
    } state_t;

    // Character classes produced by expr_char_class.
    typedef enum logic [2:0] {
        DIG = 3'd0,
        ADD = 3'd1,
        MUL = 3'd2,
        SUB = 3'd3,
        EQ  = 3'd4,
        BAD = 3'd5
    } cls_t;

    localparam logic [7:0] CH_ADD = 8'h2B;  // '+'
    localparam logic [7:0] CH_MUL = 8'h2A;  // '*'
    localparam logic [7:0] CH_EQ  = 8'h3D;  // '='
    localparam logic [7:0] CH_SUB = 8'h2D;  // '-'
    localparam logic [7:0] CH_0   = 8'h30;  // '0'
    localparam logic [7:0] CH_9   = 8'h39;  // '9'

endpackage

// File: rtl/expr_eval_if.sv
// rtl/expr_eval_if.sv - byte-stream input and result outputs of the expression evaluator
//
// Signals:
//   in_valid, in      : character source -> evaluator (byte consumed when in_valid=1)
//   result, done, err : evaluator -> consumer (registered completion strobe and value)
//   busy              : evaluator -> consumer (expression in progress)
// Modports: master = character source / consumer side, slave = evaluator.
interface expr_eval_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic [7:0]   in;
    logic [W-1:0] result;
    logic         done;
    logic         err;
    logic         busy;

    modport master (
        output in_valid, in,
        input  result, done, err, busy
    );

    modport slave (
        input  in_valid, in,
        output result, done, err, busy
    );
endinterface

// File: rtl/expr_char_class.sv
// rtl/expr_char_class.sv - combinational ASCII character classifier
//
// Ports:
//   in    : ASCII byte
//   cls   : character class (DIG/ADD/MUL/SUB/EQ/BAD)
//   digit : numeric value when cls == DIG, else 0
// Optional feature macro: EXPR_EVAL_SUB_EN (classifies '-' as SUB instead of BAD).
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0] in,
    output cls_t       cls,
    output logic [3:0] digit
);

    always_comb begin
        cls   = BAD;
        digit = 4'd0;
        if (in >= CH_0 && in <= CH_9) begin
            cls   = DIG;
            // '0'..'9' are 0x30..0x39, so the low nibble is the value.
            digit = in[3:0];
        end else begin
            case (in)
                CH_ADD:  cls = ADD;
                CH_MUL:  cls = MUL;
                CH_EQ:   cls = EQ;
`ifdef EXPR_EVAL_SUB_EN
                CH_SUB:  cls = SUB;
`endif
                default: cls = BAD;
            endcase
        end
    end

endmodule

// File: rtl/expr_eval.sv
// rtl/expr_eval.sv - streaming evaluator of single-digit '+'/'*' expressions terminated by '='
//
// Ports:
//   clk   : system clock, rising edge
//   clr_n : asynchronous active-low reset
//   bus   : expr_eval_if.slave
//           in_valid/in      - byte stream in
//           result/done/err  - registered completion, one cycle after '=' is accepted
//           busy             - high while an expression is in progress
// Parameter W: accumulator/result width, arithmetic modulo 2^W.
// Optional feature macro: EXPR_EVAL_SUB_EN (binary '-' with a negated following term).
module expr_eval
    import expr_pkg::*;
#(
    parameter int W = 16
) (
    input  logic       clk,
    input  logic       clr_n,
    expr_eval_if.slave bus
);

    cls_t         cls;
    logic [3:0]   digit;
    logic [W-1:0] dval;

    state_t       state;
    logic [W-1:0] sum;      // completed additive terms
    logic [W-1:0] prod;     // current multiplicative term
    logic [W-1:0] result_q;
    logic         done_q;
    logic         err_q;

    expr_char_class u_cls (
        .in    (bus.in),
        .cls   (cls),
        .digit (digit)
    );

    assign dval = {{(W-4){1'b0}}, digit};

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state    <= S_START;
            sum      <= '0;
            prod     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // done/err are strobes: they only live for the cycle after '='.
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.in_valid) begin
                if (cls == EQ && state != S_NUM) begin
                    // '=' anywhere but after a complete operand is a malformed expression.
                    done_q   <= 1'b1;
                    err_q    <= 1'b1;
                    result_q <= '0;
                    sum      <= '0;
                    prod     <= '0;
                    state    <= S_START;
                end else begin
                    case (state)
                        S_START: begin
                            if (cls == DIG) begin
                                prod  <= dval;
                                sum   <= '0;
                                state <= S_NUM;
                            end else begin
                                state <= S_ERR;
                            end
                        end
                        S_NUM: begin
                            case (cls)
                                ADD: begin
                                    sum   <= sum + prod;
                                    state <= S_OPA;
                                end
                                MUL: state <= S_OPM;
`ifdef EXPR_EVAL_SUB_EN
                                SUB: begin
                                    sum   <= sum + prod;
                                    state <= S_OPS;
                                end
`endif
                                EQ: begin
                                    result_q <= sum + prod;
                                    done_q   <= 1'b1;
                                    err_q    <= 1'b0;
                                    sum      <= '0;
                                    prod     <= '0;
                                    state    <= S_START;
                                end
                                default: state <= S_ERR;
                            endcase
                        end
                        S_OPA: begin
                            if (cls == DIG) begin
                                prod  <= dval;
                                state <= S_NUM;
                            end else begin
                                state <= S_ERR;
                            end
                        end
                        S_OPM: begin
                            if (cls == DIG) begin
                                prod  <= prod * dval;
                                state <= S_NUM;
                            end else begin
                                state <= S_ERR;
                            end
                        end
`ifdef EXPR_EVAL_SUB_EN
                        S_OPS: begin
                            if (cls == DIG) begin
                                // Subtraction is folded into a negated term so a later
                                // '*' scales the negative value.
                                prod  <= '0 - dval;
                                state <= S_NUM;
                            end else begin
                                state <= S_ERR;
                            end
                        end
`endif
                        S_ERR:   state <= S_ERR;
                        default: state <= S_ERR;
                    endcase
                end
            end
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.busy   = (state != S_START);

endmodule

// File: tb/tb_expr_eval.sv
// tb/tb_expr_eval.sv - self-checking bench for expr_eval against a string-level model
module tb_expr_eval;

    localparam int W = 16;

    typedef byte unsigned bq_t[$];

    logic clk   = 1'b0;
    logic clr_n = 1'b1;
    logic check_en = 1'b0;

    always #5 clk = ~clk;

    expr_eval_if #(.W(W)) bus ();

    expr_eval #(.W(W)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [15:0] last_res = '0;
    logic        last_err = 1'b0;

    bq_t         mbuf;
    logic [15:0] exp_result = '0;
    logic        exp_done = 1'b0;
    logic        exp_err  = 1'b0;
    logic        exp_busy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Evaluate a whole expression (characters before '=') with ordinary precedence.
    function automatic void model_eval(input bq_t q, output logic [15:0] v, output logic e);
        int n;
        int sum;
        int term;
        int d;
        logic op_ok;
        n = q.size();
        e = 1'b0;
        v = '0;
        if (n == 0 || (n % 2) == 0) begin
            e = 1'b1;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if ((i % 2) == 0) begin
                if (q[i] < 8'h30 || q[i] > 8'h39) e = 1'b1;
            end else begin
                op_ok = (q[i] == 8'h2B) || (q[i] == 8'h2A);
`ifdef EXPR_EVAL_SUB_EN
                op_ok = op_ok || (q[i] == 8'h2D);
`endif
                if (!op_ok) e = 1'b1;
            end
        end
        if (e) return;
        sum  = 0;
        term = int'(q[0]) - 48;
        for (int i = 1; i < n; i += 2) begin
            d = int'(q[i+1]) - 48;
            if (q[i] == 8'h2B) begin
                sum  = sum + term;
                term = d;
            end else if (q[i] == 8'h2D) begin
                sum  = sum + term;
                term = -d;
            end else begin
                term = term * d;
            end
        end
        v = 16'(sum + term);
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s.getc(i));
        return q;
    endfunction

    // Reference model: collect characters until '=', then evaluate the collected string.
    always @(posedge clk or negedge clr_n) begin
        logic [15:0] v;
        logic e;
        if (!clr_n) begin
            mbuf.delete();
            exp_result = '0;
            exp_done   = 1'b0;
            exp_err    = 1'b0;
            exp_busy   = 1'b0;
        end else begin
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (bus.in_valid) begin
                if (bus.in == 8'h3D) begin
                    model_eval(mbuf, v, e);
                    exp_done   = 1'b1;
                    exp_err    = e;
                    exp_result = e ? 16'd0 : v;
                    mbuf.delete();
                end else begin
                    mbuf.push_back(bus.in);
                end
            end
            exp_busy = (mbuf.size() != 0);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("done",   32'(bus.done),   32'(exp_done));
            chk("err",    32'(bus.err),    32'(exp_err));
            chk("result", 32'(bus.result), 32'(exp_result));
            chk("busy",   32'(bus.busy),   32'(exp_busy));
            if (bus.done === 1'b1) begin
                done_cnt++;
                last_res = bus.result;
                last_err = bus.err;
            end
        end
    end

    task automatic send_byte(input byte unsigned c, input int gap);
        bus.in_valid = 1'b1;
        bus.in       = c;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in       = 8'($urandom);
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s.getc(i), gap);
    endtask

    task automatic expect_done(input string nm, input int cnt0, input int ndone,
                               input logic [15:0] r, input logic e);
        repeat (3) @(negedge clk);
        #1;
        chk({nm, "_count"}, 32'(done_cnt), 32'(cnt0 + ndone));
        chk({nm, "_res"},   32'(last_res), 32'(r));
        chk({nm, "_err"},   32'(last_err), 32'(e));
    endtask

    initial begin
        logic [15:0] v;
        logic e;
        int c0;
        string alpha;
        string ops;
        int nt;

        bus.in_valid = 1'b0;
        bus.in       = 8'h00;
        #2 clr_n = 1'b0;
        #1 check_en = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        clr_n = 1'b1;

        // Pin the model with hand-computed values.
        model_eval(str2q("1+1*2"), v, e);         chk("model_a", 32'(v), 32'd3);
        model_eval(str2q("2*3+4*5"), v, e);       chk("model_b", 32'(v), 32'd26);
        model_eval(str2q("9*9*9*9*9*9"), v, e);   chk("model_c", 32'(v), 32'd7153);
        model_eval(str2q("1++2"), v, e);          chk("model_d", 32'(e), 32'd1);

        c0 = done_cnt; send_str("1+1*2=", 0);      expect_done("t_basic", c0, 1, 16'd3, 1'b0);
        c0 = done_cnt; send_str("2*3+4*5=", 2);    expect_done("t_gaps", c0, 1, 16'd26, 1'b0);
        c0 = done_cnt; send_str("1++2=", 0);       expect_done("t_dblop", c0, 1, 16'd0, 1'b1);
        c0 = done_cnt; send_str("7=", 0);          expect_done("t_seven", c0, 1, 16'd7, 1'b0);
        c0 = done_cnt; send_str("=", 0);           expect_done("t_lone", c0, 1, 16'd0, 1'b1);
        c0 = done_cnt; send_str("7=", 1);          expect_done("t_seven2", c0, 1, 16'd7, 1'b0);
        c0 = done_cnt; send_str("9*9*9*9*9*9=", 0); expect_done("t_wrap", c0, 1, 16'd7153, 1'b0);

        // Reset mid-expression: no completion for the aborted "1+2".
        c0 = done_cnt;
        send_str("1+2", 0);
        #2 clr_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 clr_n = 1'b1;
        send_str("3=", 0);
        expect_done("t_reset", c0, 1, 16'd3, 1'b0);

        c0 = done_cnt;
        send_str("5-2*2=", 0);
`ifdef EXPR_EVAL_SUB_EN
        expect_done("t_sub", c0, 1, 16'd1, 1'b0);
`else
        expect_done("t_sub", c0, 1, 16'd0, 1'b1);
`endif

        c0 = done_cnt; send_str("1+2=3*4=", 0);    expect_done("t_b2b", c0, 2, 16'd12, 1'b0);
        c0 = done_cnt; send_str("==", 0);          expect_done("t_eqeq", c0, 2, 16'd0, 1'b1);

        // Randomized traffic; the per-cycle compare checks every cycle.
        alpha = "0123456789+*=-x";
`ifdef EXPR_EVAL_SUB_EN
        ops = "+*-";
`else
        ops = "+*";
`endif
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                clr_n = 1'b0;
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
                clr_n = 1'b1;
            end
            if ($urandom_range(0, 2) != 0) begin
                nt = $urandom_range(1, 5);
                for (int k = 0; k < nt; k++) begin
                    if (k != 0)
                        send_byte(ops.getc($urandom_range(0, ops.len() - 1)), $urandom_range(0, 2));
                    send_byte(8'h30 + 8'($urandom_range(0, 9)), $urandom_range(0, 2));
                end
                send_byte(8'h3D, $urandom_range(0, 2));
            end else begin
                nt = $urandom_range(1, 6);
                for (int k = 0; k < nt; k++)
                    send_byte(alpha.getc($urandom_range(0, alpha.len() - 1)), $urandom_range(0, 1));
            end
        end
        send_byte(8'h3D, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
